// File: rtl/wbc_pkg.sv
// Shared definitions for the two-master control-bus arbiter: state encoding
// and default bus geometry / watchdog limit.
package wbc_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2
    } wbc_state_e;

    localparam int unsigned DEFAULT_DAT_W   = 32;
    localparam int unsigned DEFAULT_ADR_W   = 20;
    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wbc_master_arbiter_if.sv
// Bundle of both upstream Wishbone master ports, the shared downstream bus
// and the grant debug tap. The slave modport is the arbiter's view; the
// master modport is the environment's view (masters plus downstream slave).
interface wbc_master_arbiter_if
    import wbc_pkg::*;
#(
    parameter int unsigned DAT_W = DEFAULT_DAT_W,
    parameter int unsigned ADR_W = DEFAULT_ADR_W
);
    // master 0 (VIO bridge)
    logic             m0_cyc_i, m0_stb_i, m0_we_i;
    logic [ADR_W-1:0] m0_adr_i;
    logic [DAT_W-1:0] m0_dat_i;
    logic [DAT_W-1:0] m0_dat_o;
    logic             m0_ack_o, m0_err_o, m0_rty_o;
    // master 1 (host interface)
    logic             m1_cyc_i, m1_stb_i, m1_we_i;
    logic [ADR_W-1:0] m1_adr_i;
    logic [DAT_W-1:0] m1_dat_i;
    logic [DAT_W-1:0] m1_dat_o;
    logic             m1_ack_o, m1_err_o, m1_rty_o;
    // shared bus
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [DAT_W-1:0] s_dat_o;
    logic [DAT_W-1:0] s_dat_i;
    logic             s_ack_i, s_err_i, s_rty_i;
    logic [1:0]       gnt_o;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output gnt_o
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
        input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  gnt_o
    );

endinterface

// File: rtl/wbc_arb_watchdog.sv
// Stall watchdog for the arbiter: counts strobed cycles without a slave
// response and raises a one-cycle expire pulse at the limit.
// Only exists when WBC_ARB_TIMEOUT_EN is defined.
`ifdef WBC_ARB_TIMEOUT_EN
module wbc_arb_watchdog
    import wbc_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic granted,   // some master owns the bus
    input  logic stb,       // owner has cyc and stb high
    input  logic resp,      // any slave ack/err/rty this cycle
    output logic expire
);
    localparam logic [15:0] Limit = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d;

    assign expire = granted && (cnt_q == Limit);

    // Held at zero while idle so every new grant starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!granted || resp || expire) begin
            cnt_d = '0;
        end else if (stb) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/wbc_master_arbiter.sv
// Two-master round-robin Wishbone arbiter. Grant is held for a whole cyc;
// one idle bus cycle always separates owners. Optional stall watchdog is
// compiled in with WBC_ARB_TIMEOUT_EN.
module wbc_master_arbiter
    import wbc_pkg::*;
#(
    parameter int unsigned DAT_W   = DEFAULT_DAT_W,
    parameter int unsigned ADR_W   = DEFAULT_ADR_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input logic                 clk_i,
    input logic                 rst_i,
    wbc_master_arbiter_if.slave bus
);
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wbc_master_arbiter: TIMEOUT must be in 2..65535");
    end

    wbc_state_e       state_q, state_d;
    logic             last_q, last_d;   // master that released most recently
    logic             term;             // watchdog termination cycle
    logic [ADR_W-1:0] mux_adr;
    logic [DAT_W-1:0] mux_dat;

`ifdef WBC_ARB_TIMEOUT_EN
    logic granted, sel_stb, resp;

    assign granted = (state_q != StIdle);
    assign sel_stb = (state_q == StGnt0) ? (bus.m0_cyc_i & bus.m0_stb_i)
                                         : (bus.m1_cyc_i & bus.m1_stb_i);
    assign resp    = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;

    wbc_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .granted(granted),
        .stb    (sel_stb),
        .resp   (resp),
        .expire (term)
    );
`else
    assign term = 1'b0;
`endif

    // Next-state: round-robin on ties, no direct owner-to-owner hop.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (bus.m0_cyc_i) begin
                    state_d = StGnt0;
                end else if (bus.m1_cyc_i) begin
                    state_d = StGnt1;
                end
            end
            StGnt0: begin
                if (!bus.m0_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b0;
                end
            end
            StGnt1: begin
                if (!bus.m1_cyc_i) begin
                    state_d = StIdle;
                    last_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Bus mux and response routing, purely from registered grant.
    always_comb begin
        bus.gnt_o    = 2'b00;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.s_we_o   = 1'b0;
        mux_adr      = '0;
        mux_dat      = '0;
        bus.m0_dat_o = '0;
        bus.m0_ack_o = 1'b0;
        bus.m0_err_o = 1'b0;
        bus.m0_rty_o = 1'b0;
        bus.m1_dat_o = '0;
        bus.m1_ack_o = 1'b0;
        bus.m1_err_o = 1'b0;
        bus.m1_rty_o = 1'b0;
        unique case (state_q)
            StGnt0: begin
                bus.gnt_o    = 2'b01;
                bus.s_cyc_o  = bus.m0_cyc_i & ~term;
                bus.s_stb_o  = bus.m0_stb_i & ~term;
                bus.s_we_o   = bus.m0_we_i;
                mux_adr      = bus.m0_adr_i;
                mux_dat      = bus.m0_dat_i;
                bus.m0_dat_o = bus.s_dat_i;
                bus.m0_ack_o = bus.s_ack_i & ~term;
                bus.m0_err_o = bus.s_err_i | term;
                bus.m0_rty_o = bus.s_rty_i & ~term;
            end
            StGnt1: begin
                bus.gnt_o    = 2'b10;
                bus.s_cyc_o  = bus.m1_cyc_i & ~term;
                bus.s_stb_o  = bus.m1_stb_i & ~term;
                bus.s_we_o   = bus.m1_we_i;
                mux_adr      = bus.m1_adr_i;
                mux_dat      = bus.m1_dat_i;
                bus.m1_dat_o = bus.s_dat_i;
                bus.m1_ack_o = bus.s_ack_i & ~term;
                bus.m1_err_o = bus.s_err_i | term;
                bus.m1_rty_o = bus.s_rty_i & ~term;
            end
            default: ;
        endcase
    end

    assign bus.s_adr_o = mux_adr;
    assign bus.s_dat_o = mux_dat;

endmodule

// File: tb/tb_wbc_master_arbiter.sv
// Self-checking bench for wbc_master_arbiter: directed scenarios plus a
// randomized run against a transaction-level ownership model.
// Timeout scenario only runs when WBC_ARB_TIMEOUT_EN is defined.
module tb_wbc_master_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wbc_master_arbiter_if #(.DAT_W(DW), .ADR_W(AW)) bus ();

    wbc_master_arbiter #(
        .DAT_W  (DW),
        .ADR_W  (AW),
        .TIMEOUT(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    task automatic idle_inputs();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; bus.m0_adr_i = '0; bus.m0_dat_i = '0;
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.m1_we_i = 0; bus.m1_adr_i = '0; bus.m1_dat_i = '0;
        bus.s_dat_i = '0; bus.s_ack_i = 0; bus.s_err_i = 0; bus.s_rty_i = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [54:0] sbus;
        logic [34:0] r0, r1;
        idle_inputs();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1; bus.m0_adr_i = 20'hABCDE;
        bus.s_dat_i = 32'hA5A5A5A5; bus.s_ack_i = 1; bus.s_err_i = 1; bus.s_rty_i = 1;
        rst = 1'b1;
        tick();
        tick();
        #1;
        sbus = {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o};
        r0 = {bus.m0_dat_o, bus.m0_ack_o, bus.m0_err_o, bus.m0_rty_o};
        r1 = {bus.m1_dat_o, bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o};
        n_checks++; if (bus.gnt_o !== 2'b00) begin n_errors++; $display("FAIL reset_gnt got %b want 00", bus.gnt_o); end
        n_checks++; if (sbus !== '0) begin n_errors++; $display("FAIL reset_sbus got %h want 0", sbus); end
        n_checks++; if (r0 !== '0) begin n_errors++; $display("FAIL reset_m0_rsp got %h want 0", r0); end
        n_checks++; if (r1 !== '0) begin n_errors++; $display("FAIL reset_m1_rsp got %h want 0", r1); end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_single_write();
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
        bus.m0_adr_i = 20'h00010; bus.m0_dat_i = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus.s_stb_o !== 1'b0) begin n_errors++; $display("FAIL sw_stb_early got %b want 0", bus.s_stb_o); end
        tick();
        n_checks++; if (bus.gnt_o !== 2'b01) begin n_errors++; $display("FAIL sw_gnt got %b want 01", bus.gnt_o); end
        n_checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o} !== {3'b111, 20'h00010, 32'hDEADBEEF}) begin
            n_errors++;
            $display("FAIL sw_sbus got %b%b%b %h %h want 111 00010 deadbeef",
                     bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o);
        end
        n_checks++; if (bus.m0_ack_o !== 1'b0) begin n_errors++; $display("FAIL sw_ack_early got %b want 0", bus.m0_ack_o); end
        tick();
        n_checks++; if (bus.m0_ack_o !== 1'b0) begin n_errors++; $display("FAIL sw_ack_wait got %b want 0", bus.m0_ack_o); end
        tick();
        bus.s_ack_i = 1; bus.s_dat_i = 32'h0BADF00D;
        #1;
        n_checks++; if (bus.m0_ack_o !== 1'b1) begin n_errors++; $display("FAIL sw_ack got %b want 1", bus.m0_ack_o); end
        n_checks++;
        if ({bus.m1_dat_o, bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o} !== 35'd0) begin
            n_errors++; $display("FAIL sw_m1_quiet got %h ack %b want 0", bus.m1_dat_o, bus.m1_ack_o);
        end
        tick();
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.s_ack_i = 0;
        #1;
        n_checks++; if (bus.m0_ack_o !== 1'b0) begin n_errors++; $display("FAIL sw_ack_once got %b want 0", bus.m0_ack_o); end
        tick();
        n_checks++; if (bus.gnt_o !== 2'b00) begin n_errors++; $display("FAIL sw_release got %b want 00", bus.gnt_o); end
    endtask

    task automatic test_contention();
        logic [1:0] seen [6];
        logic [1:0] want [6];
        do_reset();
        want = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1; bus.m1_adr_i = 20'h55555;
        tick(); seen[0] = bus.gnt_o;
        tick(); seen[1] = bus.gnt_o;
        bus.m0_cyc_i = 0;
        tick(); seen[2] = bus.gnt_o;
        tick(); seen[3] = bus.gnt_o;
        n_checks++; if (bus.s_adr_o !== 20'h55555) begin n_errors++; $display("FAIL rr_m1_adr got %h want 55555", bus.s_adr_o); end
        bus.m1_cyc_i = 0;
        tick(); seen[4] = bus.gnt_o;
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        tick(); seen[5] = bus.gnt_o;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seen[i] !== want[i]) begin n_errors++; $display("FAIL rr_gnt[%0d] got %b want %b", i, seen[i], want[i]); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_multibeat();
        do_reset();
        bus.m0_cyc_i = 1;
        tick();
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.m0_stb_i = 1; bus.m0_adr_i = 20'(i + 1); bus.s_ack_i = 1;
            #1;
            n_checks++;
            if ({bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o, bus.s_adr_o} !== {2'b01, 2'b10, 20'(i + 1)}) begin
                n_errors++;
                $display("FAIL mb_beat%0d got gnt %b ack %b%b adr %h want 01 10 %h",
                         i, bus.gnt_o, bus.m0_ack_o, bus.m1_ack_o, bus.s_adr_o, 20'(i + 1));
            end
            tick();
        end
        bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.s_ack_i = 0;
        tick();
        n_checks++; if (bus.gnt_o !== 2'b00) begin n_errors++; $display("FAIL mb_gap got %b want 00", bus.gnt_o); end
        tick();
        n_checks++; if (bus.gnt_o !== 2'b10) begin n_errors++; $display("FAIL mb_m1 got %b want 10", bus.gnt_o); end
        idle_inputs();
        tick();
    endtask

    task automatic test_err_read();
        do_reset();
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 0; bus.m1_adr_i = 20'h00200;
        tick();
        bus.s_dat_i = 32'h12345678; bus.s_err_i = 1;
        #1;
        n_checks++; if (bus.m1_dat_o !== 32'h12345678) begin n_errors++; $display("FAIL er_m1_dat got %h want 12345678", bus.m1_dat_o); end
        n_checks++; if ({bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o} !== 3'b010) begin n_errors++; $display("FAIL er_m1_flags got %b want 010", {bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o}); end
        n_checks++; if ({bus.m0_dat_o, bus.m0_err_o} !== 33'd0) begin n_errors++; $display("FAIL er_m0_quiet got %h err %b want 0", bus.m0_dat_o, bus.m0_err_o); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
        tick();
`ifdef WBC_ARB_TIMEOUT_EN
        for (int j = 1; j <= 8; j++) begin
            n_checks++;
            if ({bus.s_cyc_o, bus.m0_err_o} !== 2'b10) begin
                n_errors++; $display("FAIL to_stall%0d got cyc %b err %b want 1 0", j, bus.s_cyc_o, bus.m0_err_o);
            end
            tick();
        end
        bus.s_ack_i = 1;
        #1;
        n_checks++;
        if ({bus.m0_err_o, bus.m0_ack_o, bus.s_cyc_o, bus.s_stb_o} !== 4'b1000) begin
            n_errors++;
            $display("FAIL to_expire got err %b ack %b cyc %b stb %b want 1 0 0 0",
                     bus.m0_err_o, bus.m0_ack_o, bus.s_cyc_o, bus.s_stb_o);
        end
        tick();
        bus.s_ack_i = 0;
        #1;
        n_checks++;
        if ({bus.m0_err_o, bus.gnt_o, bus.s_cyc_o} !== 4'b0011) begin
            n_errors++; $display("FAIL to_after got err %b gnt %b cyc %b want 0 01 1", bus.m0_err_o, bus.gnt_o, bus.s_cyc_o);
        end
`else
        for (int j = 0; j < 20; j++) tick();
        n_checks++;
        if ({bus.m0_err_o, bus.s_cyc_o, bus.gnt_o} !== 4'b0101) begin
            n_errors++; $display("FAIL to_nowd got err %b cyc %b gnt %b want 0 1 01", bus.m0_err_o, bus.s_cyc_o, bus.gnt_o);
        end
`endif
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
        tick();
        n_checks++; if (bus.gnt_o !== 2'b10) begin n_errors++; $display("FAIL rm_gnt1 got %b want 10", bus.gnt_o); end
        #2;
        rst = 1'b1;
        bus.s_ack_i = 1;
        #1;
        n_checks++;
        if ({bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.m1_ack_o} !== 5'b0) begin
            n_errors++;
            $display("FAIL rm_async got cyc %b stb %b gnt %b ack %b want 0", bus.s_cyc_o, bus.s_stb_o, bus.gnt_o, bus.m1_ack_o);
        end
        idle_inputs();
        #3;
        rst = 1'b0;
        tick();
        n_checks++; if (bus.gnt_o !== 2'b00) begin n_errors++; $display("FAIL rm_idle got %b want 00", bus.gnt_o); end
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        tick();
        n_checks++; if (bus.gnt_o !== 2'b01) begin n_errors++; $display("FAIL rm_tie got %b want 01", bus.gnt_o); end
        idle_inputs();
        tick();
    endtask

    // Model: owner (0, 1, or 2 = nobody) and the last releaser, updated from
    // the cyc levels present at each clock edge.
    task automatic test_random();
        int          owner = 2;
        int          last  = 1;
        bit          c0, c1;
        bit          stalled = 0;
        int          rsp;
        logic [1:0]  exp_gnt;
        logic [54:0] exp_s, got_s;
        logic [34:0] exp_r0, exp_r1, got_r0, got_r1;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            c0 = bus.m0_cyc_i; c1 = bus.m1_cyc_i;
            if (owner == 2) begin
                if (c0 && c1) owner = (last == 1) ? 0 : 1;
                else if (c0) owner = 0;
                else if (c1) owner = 1;
            end else if (owner == 0 && !c0) begin
                owner = 2; last = 0;
            end else if (owner == 1 && !c1) begin
                owner = 2; last = 1;
            end
            // new stimulus
            bus.m0_cyc_i = c0 ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            bus.m1_cyc_i = c1 ? ($urandom_range(3) != 0) : ($urandom_range(2) == 0);
            bus.m0_stb_i = 1'($urandom); bus.m0_we_i = 1'($urandom);
            bus.m1_stb_i = 1'($urandom); bus.m1_we_i = 1'($urandom);
            bus.m0_adr_i = 20'($urandom); bus.m0_dat_i = $urandom;
            bus.m1_adr_i = 20'($urandom); bus.m1_dat_i = $urandom;
            bus.s_dat_i  = $urandom;
            rsp = stalled ? $urandom_range(3, 1) : $urandom_range(3);
            stalled = (rsp == 0);
            bus.s_ack_i = (rsp == 1); bus.s_err_i = (rsp == 2); bus.s_rty_i = (rsp == 3);
            #1;
            exp_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            exp_s   = (owner == 0) ? {bus.m0_cyc_i, bus.m0_stb_i, bus.m0_we_i, bus.m0_adr_i, bus.m0_dat_i}
                    : (owner == 1) ? {bus.m1_cyc_i, bus.m1_stb_i, bus.m1_we_i, bus.m1_adr_i, bus.m1_dat_i}
                    : '0;
            exp_r0  = (owner == 0) ? {bus.s_dat_i, bus.s_ack_i, bus.s_err_i, bus.s_rty_i} : '0;
            exp_r1  = (owner == 1) ? {bus.s_dat_i, bus.s_ack_i, bus.s_err_i, bus.s_rty_i} : '0;
            got_s   = {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o};
            got_r0  = {bus.m0_dat_o, bus.m0_ack_o, bus.m0_err_o, bus.m0_rty_o};
            got_r1  = {bus.m1_dat_o, bus.m1_ack_o, bus.m1_err_o, bus.m1_rty_o};
            n_checks++; if (bus.gnt_o !== exp_gnt) begin n_errors++; $display("FAIL rnd_gnt cyc %0d got %b want %b", cyc, bus.gnt_o, exp_gnt); end
            n_checks++; if (got_s !== exp_s) begin n_errors++; $display("FAIL rnd_sbus cyc %0d got %h want %h", cyc, got_s, exp_s); end
            n_checks++; if (got_r0 !== exp_r0) begin n_errors++; $display("FAIL rnd_m0 cyc %0d got %h want %h", cyc, got_r0, exp_r0); end
            n_checks++; if (got_r1 !== exp_r1) begin n_errors++; $display("FAIL rnd_m1 cyc %0d got %h want %h", cyc, got_r1, exp_r1); end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_multibeat();
        test_err_read();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wbc_master_arbiter.md
# wbc_master_arbiter

Two-master Wishbone arbiter for the control clock domain. It sits directly downstream of the debug VIO bridge's Wishbone master port (master 0) and of the host-interface master (master 1), and drives the single shared control bus to the slave decoder. Grant is round-robin and held for a whole bus cycle (while `cyc` stays high), so a locked VIO sequence is never interleaved. An optional watchdog terminates stalled cycles with an error.

## Interface
Parameters:
- `DAT_W`, 32: data width.
- `ADR_W`, 20: address width.
- `TIMEOUT`, 255: watchdog limit in `clk_i` cycles (only used with the watchdog compiled in); legal range 2 to 65535.

Ports:
- `clk_i`  in  1  control clock (the clock that also runs the VIO bridge).
- `rst_i`  in  1  reset; asynchronous, active-high.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (VIO bridge) control.
- `m0_adr_i`  in  ADR_W;  `m0_dat_i`  in  DAT_W  master 0 address and write data.
- `m0_dat_o`  out  DAT_W;  `m0_ack_o`, `m0_err_o`, `m0_rty_o`  out  1 each  master 0 responses.
- `m1_*`  same set as `m0_*`  master 1 (host interface).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  shared bus control.
- `s_adr_o`  out  ADR_W;  `s_dat_o`  out  DAT_W  shared bus address and write data.
- `s_dat_i`  in  DAT_W;  `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each  slave responses.
- `gnt_o`  out  2  one-hot current grant, for debug taps.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE with `last` = 1, so master 0 wins the first tie.
- IDLE:
  - If exactly one `mX_cyc_i` is high, go to GNTX.
  - If both are high, grant the master that is not `last`.
- GNTX: stay while `mX_cyc_i` is high. When it falls, set `last` = X and return to IDLE. No direct GNT0→GNT1 hop.
- Bus muxing, combinational from registered state:
  - `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o` and `s_dat_o` follow the granted master.
  - In IDLE, `s_cyc_o` and `s_stb_o` are 0, and `s_adr_o`/`s_dat_o` are 0.
- Response routing:
  - `s_ack_i`, `s_err_i` and `s_rty_i` go only to the granted master.
  - The non-granted master sees 0 on all three and on its data output.
  - `mX_dat_o` = `s_dat_i` when granted, else 0.
- Multi-beat: multiple `stb` beats inside one `cyc` all go to the same master.
- `gnt_o`: 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.

## Timing
- Reset values:
  - all `s_*` outputs 0;
  - all `mX_ack/err/rty_o` 0, `mX_dat_o` 0;
  - `gnt_o` 00; FSM in IDLE.
- Grant latency: `cyc` rising at edge N gives grant valid after edge N+1. The slave sees `s_stb_o` one cycle after the master raised `stb`.
- Response latency: zero cycles; ack/err/rty/data are combinational pass-through.
- Release: `cyc` falling at edge N gives IDLE after edge N+1. A pending other master is granted after edge N+2. This makes one idle bus cycle mandatory between owners.
- Reset mid-cycle: outputs drop asynchronously. The master sees no ack and must restart its transfer.

## Configuration
- `WBC_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant and on any `s_ack_i`/`s_err_i`/`s_rty_i`.
  - It increments each cycle that `s_stb_o` is high without a response.
  - When it reaches `TIMEOUT`, the arbiter drives `mX_err_o` high for exactly one cycle to the granted master. During that cycle `s_cyc_o`/`s_stb_o` are forced low and any late slave response is blocked; the counter then clears.
  - The grant is held until the master drops `cyc`.
- Not defined: no counter. A stalled slave holds the bus indefinitely.

## Structure
- Shared package `wbc_pkg` holds:
  - the state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2);
  - default `DAT_W`/`ADR_W`;
  - the `TIMEOUT` default constant.
- One sub-module: `wbc_arb_watchdog` (counter plus terminate pulse), instantiated only under `WBC_ARB_TIMEOUT_EN`.

## Test plan
- Single master 0 write to adr 0x00010, data 0xDEADBEEF, slave acks after 2 cycles → slave sees the adr/data/we one cycle after `cyc`; `m0_ack_o` pulses once; `m1_*` responses stay 0.
- Both `cyc` rise on the same edge after reset → master 0 granted first. After it releases, one idle cycle, then master 1 is granted. A repeat contention grants master 0 again (round-robin).
- Master 0 holds `cyc` across 4 `stb` beats while master 1 requests → all 4 beats go to master 0; master 1 is granted only after master 0 drops `cyc`.
- Master 1 read, slave returns `s_dat_i`=0x12345678 with `s_err_i` → `m1_dat_o`=0x12345678 and `m1_err_o` pulse; `m0_dat_o` stays 0.
- With `WBC_ARB_TIMEOUT_EN` and `TIMEOUT`=8, the slave never responds → exactly 8 stalled cycles, then one `m0_err_o` pulse with `s_cyc_o`=0 in that cycle; a late `s_ack_i` in that cycle is not forwarded.
- Assert `rst_i` while in GNT1 with `stb` high → `s_cyc_o`, `s_stb_o` and `gnt_o` go to 0 asynchronously; after release the FSM is IDLE and master 0 wins the next tie.
